// File: rtl/boot_loader_pkg.sv
// rtl/boot_loader_pkg.sv - shared types and frame constants for the boot loader
package boot_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [7:0] DEFAULT_MAGIC = 8'hA5;
    localparam int         LEN_WIDTH     = 16;
    localparam int         CHK_WIDTH     = 8;

endpackage

// File: rtl/boot_loader_word_packer.sv
// rtl/boot_loader_word_packer.sv - assembles little-endian bytes into 32-bit words
module word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic [1:0]  o_lane,
    output logic        o_word_valid,
    output logic [31:0] o_word
);

    logic [1:0]  r_lane;
    logic [23:0] r_shift;
    logic        r_word_valid;
    logic [31:0] r_word;

    // Bytes enter at the top so the first byte of a word lands in bits [7:0].
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lane       <= 2'd0;
            r_shift      <= 24'd0;
            r_word_valid <= 1'b0;
            r_word       <= 32'd0;
        end else begin
            r_word_valid <= 1'b0;
            if (i_clear) begin
                r_lane  <= 2'd0;
                r_shift <= 24'd0;
            end else if (i_byte_valid) begin
                r_lane <= r_lane + 2'd1;
                if (r_lane == 2'd3) begin
                    r_word       <= {i_byte, r_shift};
                    r_word_valid <= 1'b1;
                end else begin
                    r_shift <= {i_byte, r_shift[23:8]};
                end
            end
        end
    end

    assign o_lane       = r_lane;
    assign o_word_valid = r_word_valid;
    assign o_word       = r_word;

endmodule

// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - loads a framed, checksummed image into instruction memory
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int         ADDR_WIDTH     = 10,
    parameter logic [7:0] MAGIC          = DEFAULT_MAGIC,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_rst,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int          TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [31:0] CAPACITY = 32'd1 << ADDR_WIDTH;

    state_t                 r_state;
    state_t                 w_next;
    logic [7:0]             r_len_lo;
    logic [LEN_WIDTH-1:0]   r_len;
    logic [LEN_WIDTH-1:0]   r_word_idx;
    logic [CHK_WIDTH-1:0]   r_sum;
    logic [TW-1:0]          r_idle;
    logic [ADDR_WIDTH-1:0]  r_imem_addr;
    logic                   r_core_rst;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_error;

    logic                   w_accept;
    logic                   w_in_frame;
    logic                   w_timeout;
    logic                   w_frame_start;
    logic                   w_data_byte;
    logic                   w_word_end;
    logic                   w_last_word;
    logic [LEN_WIDTH-1:0]   w_len_full;
    logic [CHK_WIDTH-1:0]   w_chk_sum;
    logic [1:0]             w_lane;
    logic                   w_word_valid;
    logic [31:0]            w_word;
    logic                   w_busy_next;

    assign w_accept      = in_valid;
    assign w_in_frame    = (r_state == ST_LEN_LO) || (r_state == ST_LEN_HI) ||
                           (r_state == ST_DATA)   || (r_state == ST_CHK);
    assign w_timeout     = w_in_frame && !w_accept && (r_idle == TW'(TIMEOUT_CYCLES - 1));
    assign w_frame_start = w_accept && (in_data == MAGIC) &&
                           ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR));
    assign w_data_byte   = w_accept && (r_state == ST_DATA);
    assign w_word_end    = w_data_byte && (w_lane == 2'd3);
    assign w_last_word   = (r_word_idx == r_len - 16'd1);
    assign w_len_full    = {in_data, r_len_lo};
    assign w_chk_sum     = r_sum + in_data;

    word_packer u_word_packer (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_frame_start),
        .i_byte_valid (w_data_byte),
        .i_byte       (in_data),
        .o_lane       (w_lane),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    // An accepted byte always wins over the idle timeout in the same cycle.
    always_comb begin
        w_next = r_state;
        if (w_timeout) begin
            w_next = ST_ERR;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (w_frame_start) w_next = ST_LEN_LO;
                end
                ST_LEN_LO: begin
                    if (w_accept) w_next = ST_LEN_HI;
                end
                ST_LEN_HI: begin
                    if (w_accept) begin
                        if (32'(w_len_full) > CAPACITY) w_next = ST_ERR;
                        else if (w_len_full == 16'd0)   w_next = ST_CHK;
                        else                            w_next = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_word_end && w_last_word) w_next = ST_CHK;
                end
                ST_CHK: begin
                    if (w_accept) w_next = (w_chk_sum == 8'd0) ? ST_DONE : ST_ERR;
                end
                default: w_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_busy_next = 1'b0;
        case (w_next)
            ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CHK: w_busy_next = 1'b1;
            default:                               w_busy_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_len_lo    <= 8'd0;
            r_len       <= '0;
            r_word_idx  <= '0;
            r_sum       <= '0;
            r_idle      <= '0;
            r_imem_addr <= '0;
            r_core_rst  <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_core_rst <= (w_next != ST_DONE);
            r_busy     <= w_busy_next;
            r_done     <= (w_next == ST_DONE);
            r_error    <= (w_next == ST_ERR);

            if (w_frame_start) begin
                r_word_idx <= '0;
                r_sum      <= '0;
            end
            if (w_accept && (r_state == ST_LEN_LO)) r_len_lo <= in_data;
            if (w_accept && (r_state == ST_LEN_HI)) r_len    <= w_len_full;
            if (w_data_byte) r_sum <= r_sum + in_data;
            // The address is captured with the 4th byte so it lines up with the packer's pulse.
            if (w_word_end) begin
                r_imem_addr <= r_word_idx[ADDR_WIDTH-1:0];
                r_word_idx  <= r_word_idx + 16'd1;
            end

            if (!w_in_frame || w_accept) r_idle <= '0;
            else                         r_idle <= r_idle + TW'(1);
        end
    end

    assign in_ready   = 1'b1;
    assign imem_we    = w_word_valid;
    assign imem_addr  = r_imem_addr;
    assign imem_wdata = w_word;
    assign core_rst   = r_core_rst;
    assign busy       = r_busy;
    assign done       = r_done;
    assign error      = r_error;

endmodule

// File: tb/tb_boot_loader.sv
// tb/tb_boot_loader.sv - self-checking bench for boot_loader
module tb_boot_loader;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [3:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst;
    logic        busy;
    logic        done;
    logic        error;

    int errors = 0;
    int checks = 0;

    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [31:0] exp_words[$];

    boot_loader #(
        .ADDR_WIDTH     (4),
        .MAGIC          (8'hA5),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_addr_q.push_back(32'(imem_addr));
            wr_data_q.push_back(imem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input bq_t fr);
        foreach (fr[i]) send_byte(fr[i]);
    endtask

    task automatic check_writes(input string tag);
        int n;
        check({tag, " write count"}, 32'(wr_data_q.size()), 32'(exp_words.size()));
        n = (wr_data_q.size() < exp_words.size()) ? wr_data_q.size() : exp_words.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s addr[%0d]", tag, i), wr_addr_q[i], 32'(i));
            check($sformatf("%s data[%0d]", tag, i), wr_data_q[i], exp_words[i]);
        end
        wr_addr_q = {};
        wr_data_q = {};
    endtask

    task automatic check_status(input string tag, input logic exp_done);
        check({tag, " done"},     32'(done),     32'(exp_done));
        check({tag, " error"},    32'(error),    32'(!exp_done));
        check({tag, " core_rst"}, 32'(core_rst), 32'(!exp_done));
        check({tag, " busy"},     32'(busy),     32'(0));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " imem_we"},    32'(imem_we),    32'(0));
        check({tag, " imem_addr"},  32'(imem_addr),  32'(0));
        check({tag, " imem_wdata"}, imem_wdata,      32'(0));
        check({tag, " core_rst"},   32'(core_rst),   32'(1));
        check({tag, " busy"},       32'(busy),       32'(0));
        check({tag, " done"},       32'(done),       32'(0));
        check({tag, " error"},      32'(error),      32'(0));
        check({tag, " in_ready"},   32'(in_ready),   32'(1));
    endtask

    initial begin
        bq_t         fr;
        bq_t         t1;
        int          n;
        logic [7:0]  sum;
        logic [7:0]  b;
        logic [31:0] w;
        logic        ok;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        idle(3);
        check_reset_values("reset");
        rst = 1'b0;
        idle(1);

        t1 = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
               8'h93, 8'h00, 8'h10, 8'h00, 8'h4A};

        // test 1: good two-word image
        exp_words = '{32'h0000_0013, 32'h0010_0093};
        send_byte(8'hA5);
        check("t1 busy after magic", 32'(busy), 32'(1));
        for (int i = 1; i < t1.size(); i++) send_byte(t1[i]);
        idle(2);
        check_writes("t1");
        check_status("t1", 1'b1);

        // test 2: bad checksum, same writes
        fr = t1;
        fr[11] = 8'h4B;
        send_frame(fr);
        idle(2);
        check_writes("t2");
        check_status("t2", 1'b0);

        // test 3: empty image
        exp_words = {};
        send_frame('{8'hA5, 8'h00, 8'h00, 8'h00});
        idle(2);
        check_writes("t3");
        check_status("t3", 1'b1);

        // test 4: oversize length, then a valid one-word frame
        send_frame('{8'hA5, 8'h11, 8'h00});
        check("t4 error after length", 32'(error), 32'(1));
        check("t4 busy after length",  32'(busy),  32'(0));
        idle(2);
        check_writes("t4 oversize");
        exp_words = '{32'h0000_0001};
        send_frame('{8'hA5, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'hFF});
        idle(2);
        check_writes("t4 valid");
        check_status("t4", 1'b1);

        // test 5: timeout mid-word
        exp_words = {};
        send_frame('{8'hA5, 8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC});
        idle(15);
        check("t5 still busy at 15 idle", 32'(busy),  32'(1));
        check("t5 no error at 15 idle",   32'(error), 32'(0));
        idle(1);
        check("t5 error at 16 idle", 32'(error),    32'(1));
        check("t5 busy at 16 idle",  32'(busy),     32'(0));
        check("t5 core_rst",         32'(core_rst), 32'(1));
        check_writes("t5");
        send_byte(8'hA5);
        check("t5 restart busy",  32'(busy),  32'(1));
        check("t5 restart error", 32'(error), 32'(0));
        send_frame('{8'h00, 8'h00, 8'h00});
        idle(1);
        check_status("t5 restart", 1'b1);

        // test 6: reset during data, then full reload
        for (int i = 0; i < 6; i++) send_byte(t1[i]);
        rst = 1'b1;
        idle(1);
        check_reset_values("t6 reset");
        rst = 1'b0;
        check_writes("t6 partial");
        exp_words = '{32'h0000_0013, 32'h0010_0093};
        send_frame(t1);
        idle(2);
        check_writes("t6 reload");
        check_status("t6", 1'b1);

        // random frames against a frame-level model
        for (int f = 0; f < 30; f++) begin
            repeat ($urandom_range(0, 2)) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'hA5) b = 8'h00;
                send_byte(b);
            end
            n = $urandom_range(0, 17);
            fr = '{8'hA5, 8'(n), 8'h00};
            exp_words = {};
            sum = 8'h00;
            if (n <= 16) begin
                for (int k = 0; k < n; k++) begin
                    w = $urandom();
                    if ($urandom_range(0, 3) == 0) w[7:0] = 8'hA5;
                    exp_words.push_back(w);
                    for (int j = 0; j < 4; j++) begin
                        fr.push_back(w[8*j +: 8]);
                        sum = sum + w[8*j +: 8];
                    end
                end
                ok = ($urandom_range(0, 3) != 0);
                b = 8'h00 - sum;
                if (!ok) b = b + 8'($urandom_range(1, 255));
                fr.push_back(b);
            end else begin
                ok = 1'b0;
            end
            foreach (fr[i]) begin
                send_byte(fr[i]);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
            idle(2);
            check_writes($sformatf("rand%0d", f));
            check_status($sformatf("rand%0d", f), ok);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
